// File: rtl/freq_meter_pkg.sv
// freq_meter_pkg
//   Shared types and default sizing for the gated frequency meter.
//   state_t          : measurement FSM encoding (IDLE / MEASURE / REPORT)
//   DEF_GATE_CYCLES  : clk cycles per gate, 1 s at a 40 MHz system clock
//   DEF_CNT_W        : width of the edge counter and of the freq result
package freq_meter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_REPORT  = 2'd2
    } state_t;

    localparam int DEF_GATE_CYCLES = 40_000_000;
    localparam int DEF_CNT_W       = 20;

endpackage

// File: rtl/freq_meter_if.sv
// freq_meter_if
//   Control / result bundle of the frequency meter.
//   enable   : requester -> meter, keep high for back-to-back gates
//   sig_in   : requester -> meter, asynchronous square wave under test
//   freq     : meter -> requester, rising-edge count of last completed gate
//   valid    : meter -> requester, one-cycle pulse on a new freq/overflow
//   overflow : meter -> requester, last completed gate saturated the counter
//   busy     : meter -> requester, FSM is not IDLE
interface freq_meter_if
    import freq_meter_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
);
    logic             enable;
    logic             sig_in;
    logic [CNT_W-1:0] freq;
    logic             valid;
    logic             overflow;
    logic             busy;

    modport master (
        output enable, sig_in,
        input  freq, valid, overflow, busy
    );

    modport slave (
        input  enable, sig_in,
        output freq, valid, overflow, busy
    );
endinterface

// File: rtl/freq_meter_sync_edge_det.sv
// sync_edge_det
//   Two-flop synchronizer plus a history flop; emits a one-cycle pulse on
//   each rising edge of an asynchronous input.
//   clk     : system clock
//   reset   : synchronous, active-low
//   d_async : asynchronous input
//   rise    : one-cycle rising-edge pulse, valid in the cycle after the
//             second synchronizer stage captures the new level
module sync_edge_det (
    input  logic clk,
    input  logic reset,
    input  logic d_async,
    output logic rise
);
    logic r_s1;
    logic r_s2;
    logic r_hist;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_s1   <= 1'b0;
            r_s2   <= 1'b0;
            r_hist <= 1'b0;
        end else begin
            r_s1   <= d_async;
            r_s2   <= r_s1;
            r_hist <= r_s2;
        end
    end

    // A level held high through reset release reads as one fresh edge,
    // because the history flop comes out of reset at 0.
    assign rise = r_s2 & ~r_hist;

endmodule

// File: rtl/freq_meter.sv
// freq_meter
//   Counts rising edges of an asynchronous signal over a fixed gate of
//   GATE_CYCLES clk cycles, reports the count for one cycle, and repeats
//   while enable stays high. Counter saturates with a sticky overflow.
//   clk   : system clock
//   reset : synchronous, active-low
//   bus   : freq_meter_if.slave (enable, sig_in in; freq, valid,
//           overflow, busy out)
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int GATE_CYCLES = DEF_GATE_CYCLES,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic          clk,
    input  logic          reset,
    freq_meter_if.slave   bus
);
    localparam int               GW        = $clog2(GATE_CYCLES);
    localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    state_t           r_state;
    state_t           w_next;
    logic [GW-1:0]    r_gate;
    logic [CNT_W-1:0] r_edges;
    logic             r_sticky;
    logic [CNT_W-1:0] r_freq;
    logic             r_ovf;

    logic             w_rise;
    logic             w_last;
    logic             w_sat;
    logic [CNT_W-1:0] w_edges_nx;
    logic             w_sticky_nx;
    logic             w_counting;

    // Runs in every state so the edge history is always current.
    sync_edge_det u_sync (
        .clk     (clk),
        .reset   (reset),
        .d_async (bus.sig_in),
        .rise    (w_rise)
    );

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:    if (bus.enable) w_next = ST_MEASURE;
            ST_MEASURE: begin
                // Abort wins over gate completion.
                if (!bus.enable)  w_next = ST_IDLE;
                else if (w_last)  w_next = ST_REPORT;
            end
            ST_REPORT:  w_next = bus.enable ? ST_MEASURE : ST_IDLE;
            default:    w_next = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        bus.valid = (r_state == ST_REPORT);
        bus.busy  = (r_state != ST_IDLE);
    end

    // ---------------- gate / edge counting ----------------
    assign w_last      = (r_gate == GATE_LAST);
    assign w_sat       = w_rise && (r_edges == CNT_MAX);
    assign w_edges_nx  = (w_rise && !w_sat) ? r_edges + CNT_W'(1) : r_edges;
    assign w_sticky_nx = r_sticky | w_sat;
    // Abort cycles do not count; the counters simply clear.
    assign w_counting  = (r_state == ST_MEASURE) && bus.enable;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_gate   <= '0;
            r_edges  <= '0;
            r_sticky <= 1'b0;
            r_freq   <= '0;
            r_ovf    <= 1'b0;
        end else if (w_counting && !w_last) begin
            r_gate   <= r_gate + GW'(1);
            r_edges  <= w_edges_nx;
            r_sticky <= w_sticky_nx;
        end else begin
            // Last gate cycle captures the result including its own edge;
            // counters are zero through REPORT so the next gate starts clean.
            if (w_counting) begin
                r_freq <= w_edges_nx;
                r_ovf  <= w_sticky_nx;
            end
            r_gate   <= '0;
            r_edges  <= '0;
            r_sticky <= 1'b0;
        end
    end

    assign bus.freq     = r_freq;
    assign bus.overflow = r_ovf;

endmodule

// File: tb/tb_freq_meter.sv
// tb_freq_meter
//   Directed bench: two meters (CNT_W=20 and CNT_W=4), GATE_CYCLES=100.
//   Inputs are driven and outputs sampled on the falling clock edge.
module tb_freq_meter;
    localparam int GC = 100;

    logic clk;
    logic reset;
    logic en_a, en_b;
    logic sig_in;
    int   sig_per, sig_ph;
    int   n_tests, n_fail;

    freq_meter_if #(.CNT_W(20)) bus  ();
    freq_meter_if #(.CNT_W(4))  bus4 ();

    assign bus.enable  = en_a;
    assign bus.sig_in  = sig_in;
    assign bus4.enable = en_b;
    assign bus4.sig_in = sig_in;

    freq_meter #(.GATE_CYCLES(GC), .CNT_W(20)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    freq_meter #(.GATE_CYCLES(GC), .CNT_W(4)) dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Periodic square wave when sig_per != 0, otherwise sig_in is manual.
    always @(negedge clk) begin
        if (sig_per != 0) begin
            sig_in = (sig_ph < sig_per / 2);
            sig_ph = (sig_ph + 1 >= sig_per) ? 0 : sig_ph + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Advance to the next falling edge with valid high; n = edges advanced.
    task automatic wait_valid(input string tag, input bit sel, output int n);
        logic v;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            v = sel ? bus4.valid : bus.valid;
        end while (!v && n < 1000);
        if (!v) chk({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        int n, nv;
        n_tests = 0; n_fail = 0;
        reset = 1'b0; en_a = 1'b0; en_b = 1'b0;
        sig_in = 1'b0; sig_ph = 0; sig_per = 10;

        // ---- reset state ----
        tick(3);
        chk("rst_freq",  bus.freq,     0);
        chk("rst_valid", bus.valid,    0);
        chk("rst_ovf",   bus.overflow, 0);
        chk("rst_busy",  bus.busy,     0);
        reset = 1'b1;
        tick(5);
        chk("idle_busy", bus.busy, 0);

        // ---- continuous gates, period 10 ----
        en_a = 1'b1;
        tick(1);
        chk("start_busy", bus.busy, 1);
        chk("start_valid", bus.valid, 0);
        // The MEASURE-entry edge precedes this sample, so the REPORT
        // cycle is the 101st after it; one sample is already consumed.
        wait_valid("g1", 1'b0, n);
        chk("g1_latency", n + 1, 101);
        chk("g1_freq", bus.freq, 10);
        chk("g1_ovf",  bus.overflow, 0);
        wait_valid("g2", 1'b0, n);
        chk("g2_period", n, 101);
        chk("g2_freq", bus.freq, 10);

        // ---- abort at gate cycle 50 ----
        tick(51);
        chk("abort_pre_busy", bus.busy, 1);
        en_a = 1'b0;
        tick(1);
        chk("abort_busy",  bus.busy,  0);
        chk("abort_valid", bus.valid, 0);
        chk("abort_freq",  bus.freq,  10);
        nv = 0;
        for (int i = 0; i < 120; i++) begin
            tick(1);
            if (bus.valid) nv++;
        end
        chk("abort_no_valid", nv, 0);
        chk("abort_freq_hold", bus.freq, 10);

        // ---- reset pulse at gate cycle 60 ----
        en_a = 1'b1;
        tick(1);
        tick(60);
        reset = 1'b0;
        tick(1);
        chk("mrst_freq",  bus.freq,     0);
        chk("mrst_valid", bus.valid,    0);
        chk("mrst_ovf",   bus.overflow, 0);
        chk("mrst_busy",  bus.busy,     0);
        reset = 1'b1;
        tick(1);
        chk("mrst_restart_busy", bus.busy, 1);
        wait_valid("mrst_g1", 1'b0, n);
        chk("mrst_g1_latency", n, 100);
        wait_valid("mrst_g2", 1'b0, n);
        chk("mrst_g2_period", n, 101);
        chk("mrst_g2_freq", bus.freq, 10);
        en_a = 1'b0;
        tick(3);

        // ---- saturation on the 4-bit meter ----
        sig_per = 4; sig_ph = 0;
        en_b = 1'b1;
        tick(1);
        tick(90);
        sig_per = 0; sig_in = 1'b0;
        wait_valid("sat", 1'b1, n);
        chk("sat_latency", n, 10);
        chk("sat_freq", bus4.freq, 15);
        chk("sat_ovf",  bus4.overflow, 1);
        wait_valid("quiet", 1'b1, n);
        chk("quiet_freq", bus4.freq, 0);
        chk("quiet_ovf",  bus4.overflow, 0);
        en_b = 1'b0;
        chk("idle_a_freq", bus.freq, 10);
        tick(5);

        // ---- edge landing in last gate cycle vs REPORT cycle ----
        en_a = 1'b1;
        tick(1);
        tick(97);
        sig_in = 1'b1;        // edge pulse lands in gate cycle 99
        wait_valid("edge_last", 1'b0, n);
        chk("edge_last_lat", n, 3);
        chk("edge_last_freq", bus.freq, 1);
        sig_in = 1'b0;
        tick(1);
        tick(98);
        sig_in = 1'b1;        // edge pulse lands in the REPORT cycle
        wait_valid("edge_rep", 1'b0, n);
        chk("edge_rep_lat", n, 2);
        chk("edge_rep_freq", bus.freq, 0);
        wait_valid("edge_after", 1'b0, n);
        chk("edge_after_freq", bus.freq, 0);
        en_a = 1'b0;
        tick(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/freq_meter.md
FREQ_METER -- requirements
Module: freq_meter

Interface
REQ-001 Parameter GATE_CYCLES, default 40_000_000: clk cycles per measurement gate, which is 1 s at the 40 MHz system clock; legal minimum is 2.
REQ-002 Parameter CNT_W, default 20: width of the edge counter and of the freq output.
REQ-003 Port clk  input  1: single system clock; all state changes on its rising edge.
REQ-004 Port reset  input  1: synchronous, active-low reset.
REQ-005 Port enable  input  1: high requests continuous back-to-back measurements; low stops or aborts them.
REQ-006 Port sig_in  input  1: asynchronous external square wave to be measured.
REQ-007 Port freq  output  CNT_W: rising-edge count of the last completed gate, in Hz when GATE_CYCLES equals 1 s.
REQ-008 Port valid  output  1: one-cycle pulse marking a new freq/overflow value.
REQ-009 Port overflow  output  1: the last completed gate saturated the counter.
REQ-010 Port busy  output  1: high whenever the state is not IDLE.

Function
REQ-011 sig_in SHALL pass through a 2-flop synchronizer plus one history flop; rising edge = sync2 & ~hist; latency from the sig_in transition to the edge pulse is 3 clk cycles.
REQ-012 The synchronizer SHALL run in every state, so edges are detected even when they are not counted.
REQ-013 FSM states SHALL be IDLE, MEASURE and REPORT.
REQ-014 IDLE -> MEASURE SHALL occur on the first clk edge that samples enable=1; the gate counter and edge counter are 0 in the first MEASURE cycle.
REQ-015 MEASURE SHALL last exactly GATE_CYCLES cycles, with the gate counter running from 0 to GATE_CYCLES-1.
REQ-016 In MEASURE, an edge pulse SHALL increment the edge counter, including an edge in the final cycle.
REQ-017 If the edge counter is 2^CNT_W-1 when an edge arrives, the counter SHALL hold that value and a sticky overflow flag SHALL be set.
REQ-018 At the end of the last MEASURE cycle, freq SHALL load the edge count including that cycle's edge, and overflow SHALL load the sticky flag; the state then moves to REPORT.
REQ-019 REPORT SHALL last exactly one cycle with valid=1.
REQ-020 In REPORT, the counters and the sticky flag SHALL clear; edges are not counted (one dead cycle per gate).
REQ-021 REPORT -> MEASURE if enable=1 in that cycle, else REPORT -> IDLE.
REQ-022 enable=0 sampled in MEASURE SHALL abort to IDLE on the next edge, with no valid pulse; freq and overflow hold their previous values and the counters clear.
REQ-023 freq and overflow SHALL change only on entry to REPORT and on reset.
REQ-024 valid SHALL be 0 in IDLE and MEASURE.
REQ-025 busy SHALL be registered-state derived: 1 in MEASURE and REPORT, 0 in IDLE.
REQ-026 Period between valid pulses under continuous enable SHALL be exactly GATE_CYCLES+1 cycles.

Reset
REQ-027 reset=0 sampled on a clk edge SHALL force: state IDLE, all counters 0, sticky flag 0, synchronizer and history flops 0, freq 0, valid 0, overflow 0, busy 0.
REQ-028 Reset SHALL take priority over enable and over any in-progress gate; a mid-MEASURE reset produces no valid pulse.
REQ-029 A sig_in held high through reset release SHALL be seen as one rising edge 2 cycles later; this edge is counted only if MEASURE is already active.

Structure
REQ-030 Package freq_meter_pkg SHALL hold the FSM state enum and the default GATE_CYCLES and CNT_W constants.
REQ-031 The synchronizer and edge detector SHALL be a sub-module sync_edge_det (ports clk, reset, d_async, rise), reusable for the sensor inputs elsewhere in the system.
REQ-032 The gate counter width SHALL be $clog2(GATE_CYCLES); no arithmetic on freq beyond counting.

Verification (GATE_CYCLES=100, CNT_W=20 unless stated)
REQ-033 enable=1 held, sig_in period 10 clk phase-aligned: first valid exactly 101 cycles after the IDLE->MEASURE edge, freq=10, overflow=0; later valids are spaced 101 cycles apart.
REQ-034 CNT_W=4, sig_in period 4 clk (25 edges per gate): freq=15, overflow=1; next gate with sig_in stuck low gives freq=0, overflow=0.
REQ-035 enable dropped at gate cycle 50: busy=0 on the next cycle, no valid pulse, freq keeps its previous value.
REQ-036 reset=0 for 1 cycle at gate cycle 60: all outputs 0 on the next cycle, no valid pulse; with enable still 1, a new gate starts on the following sampled edge.
REQ-037 sig_in edge placed exactly at the last gate cycle vs. at the REPORT cycle (after 3-cycle sync latency): counted vs. not counted respectively, giving freq differing by 1.
